// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller for the P7 pipeline.
// Owns HI/LO, sequences fixed-latency mult/div, and raises the D-stage MD stall.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDop,
    input  logic        req,
    input  logic        D_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] counter;
    logic [31:0]      hi_tmp;
    logic [31:0]      lo_tmp;
    logic             commit_pending;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             is_arith;
    logic             done;
    logic             mt_ok;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             a_neg;
    logic             b_neg;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      uden;
    logic [31:0]      sden;
    logic [31:0]      uq;
    logic [31:0]      ur;
    logic [31:0]      mq;
    logic [31:0]      mr;
    logic [31:0]      sq;
    logic [31:0]      sr;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_commit;
    logic [CNT_W-1:0] res_cycles;

    // Products: operands are explicitly extended so the low 64 bits are exact.
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division via magnitudes, so 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    // A zero divisor is replaced by 1 only to keep the dividers X-free; that result is never committed.
    assign a_neg = A[31];
    assign b_neg = B[31];
    assign a_mag = a_neg ? (32'd0 - A) : A;
    assign b_mag = b_neg ? (32'd0 - B) : B;
    assign uden  = (B == 32'd0) ? 32'd1 : B;
    assign sden  = (B == 32'd0) ? 32'd1 : b_mag;
    assign uq    = A / uden;
    assign ur    = A % uden;
    assign mq    = a_mag / sden;
    assign mr    = a_mag % sden;
    assign sq    = (a_neg ^ b_neg) ? (32'd0 - mq) : mq;
    assign sr    = a_neg ? (32'd0 - mr) : mr;

    always_comb begin
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_commit = 1'b0;
        res_cycles = '0;
        case (MDop)
            OP_MULT: begin
                res_hi     = prod_s[63:32];
                res_lo     = prod_s[31:0];
                res_commit = 1'b1;
                res_cycles = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
                res_hi     = prod_u[63:32];
                res_lo     = prod_u[31:0];
                res_commit = 1'b1;
                res_cycles = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
                res_hi     = sr;
                res_lo     = sq;
                res_commit = (B != 32'd0);
                res_cycles = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                res_hi     = ur;
                res_lo     = uq;
                res_commit = (B != 32'd0);
                res_cycles = CNT_W'(DIV_CYCLES);
            end
            default: begin
                res_hi     = 32'd0;
                res_lo     = 32'd0;
                res_commit = 1'b0;
                res_cycles = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        is_arith   = (MDop >= OP_MULT) && (MDop <= OP_DIVU);
        start      = 1'b0;
        done       = 1'b0;
        mt_ok      = 1'b0;
        case (state)
            IDLE: begin
                start = is_arith && !req;
                mt_ok = !req;
                if (start) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                done = (counter == CNT_W'(1));
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter        <= '0;
            hi_tmp         <= 32'd0;
            lo_tmp         <= 32'd0;
            commit_pending <= 1'b0;
            hi_q           <= 32'd0;
            lo_q           <= 32'd0;
        end else begin
            if (start) begin
                counter        <= res_cycles;
                hi_tmp         <= res_hi;
                lo_tmp         <= res_lo;
                commit_pending <= res_commit;
            end else if (state == BUSY) begin
                counter <= counter - CNT_W'(1);
                if (done) begin
                    commit_pending <= 1'b0;
                    if (commit_pending) begin
                        hi_q <= hi_tmp;
                        lo_q <= lo_tmp;
                    end
                end
            end
            if (mt_ok && (MDop == OP_MTHI)) begin
                hi_q <= A;
            end
            if (mt_ok && (MDop == OP_MTLO)) begin
                lo_q <= A;
            end
        end
    end

    assign busy  = (state == BUSY);
    assign stall = D_is_md && (busy || start);
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: a vector table of MD operations plus
// hand-written sequences for divide-by-zero, stall, req and mid-op reset.
module tb_e_mdu_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDop;
    logic        req;
    logic        D_is_md;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[7];

    e_mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .A      (A),
        .B      (B),
        .MDop   (MDop),
        .req    (req),
        .D_is_md(D_is_md),
        .start  (start),
        .busy   (busy),
        .stall  (stall),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one arithmetic op for a single cycle, then count busy cycles (bounded).
    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int n);
        @(negedge clk);
        MDop = op;
        A    = a;
        B    = b;
        #1;
        check_output("start_on_issue", {31'd0, start}, 32'd1);
        @(negedge clk);
        MDop = 4'd0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_hilo(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        MDop = op;
        A    = val;
        @(negedge clk);
        MDop = 4'd0;
    endtask

    initial begin
        int n;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        A       = 32'd0;
        B       = 32'd0;
        MDop    = 4'd0;
        req     = 1'b0;
        D_is_md = 1'b0;

        vecs[0] = '{"mult_neg1x2",  4'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{"multu_max_x2", 4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{"mult_big",     4'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 5};
        vecs[3] = '{"div_m7_2",     4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{"div_7_m2",     4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[5] = '{"divu_7_2",     4'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[6] = '{"div_ovf",      4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};

        @(negedge clk);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_hi", HI, 32'd0);
        check_output("reset_lo", LO, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check_output({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cycles));
            check_output({vecs[i].name, "_hi"}, HI, vecs[i].hi);
            check_output({vecs[i].name, "_lo"}, LO, vecs[i].lo);
        end

        // Divide by zero keeps preloaded HI/LO but still takes the full latency.
        write_hilo(4'd5, 32'h11);
        write_hilo(4'd6, 32'h22);
        check_output("mthi_write", HI, 32'h11);
        check_output("mtlo_write", LO, 32'h22);
        apply_stimulus(4'd3, 32'h00000064, 32'd0, n);
        check_output("divzero_cycles", 32'(n), 32'd10);
        check_output("divzero_hi", HI, 32'h11);
        check_output("divzero_lo", LO, 32'h22);

        // req suppresses starts and mthi/mtlo.
        @(negedge clk);
        MDop = 4'd1; A = 32'd9; B = 32'd9; req = 1'b1;
        #1;
        check_output("req_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        check_output("req_busy", {31'd0, busy}, 32'd0);
        check_output("req_hi", HI, 32'h11);
        check_output("req_lo", LO, 32'h22);
        MDop = 4'd5; A = 32'h99;
        @(negedge clk);
        check_output("req_mthi", HI, 32'h11);
        MDop = 4'd0; req = 1'b0;

        // req raised while busy must not cancel the commit.
        @(negedge clk);
        MDop = 4'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        MDop = 4'd0;
        req  = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        req = 1'b0;
        check_output("req_busy_cycles", 32'(n), 32'd5);
        check_output("req_busy_hi", HI, 32'd0);
        check_output("req_busy_lo", LO, 32'd12);

        // Stall: high in the start cycle and every busy cycle, low once busy falls.
        D_is_md = 1'b1;
        @(negedge clk);
        MDop = 4'd2; A = 32'd5; B = 32'd6;
        #1;
        check_output("stall_start", {31'd0, stall}, 32'd1);
        @(negedge clk);
        MDop = 4'd0;
        n = 0;
        while (busy && n < 200) begin
            check_output("stall_busy", {31'd0, stall}, 32'd1);
            n++;
            @(negedge clk);
        end
        check_output("stall_cycles", 32'(n), 32'd5);
        check_output("stall_after", {31'd0, stall}, 32'd0);
        check_output("stall_res_lo", LO, 32'd30);

        D_is_md = 1'b0;
        @(negedge clk);
        MDop = 4'd4; A = 32'd9; B = 32'd4;
        @(negedge clk);
        MDop = 4'd0;
        n = 0;
        while (busy && n < 200) begin
            check_output("nostall_busy", {31'd0, stall}, 32'd0);
            n++;
            @(negedge clk);
        end
        check_output("nostall_cycles", 32'(n), 32'd10);
        check_output("nostall_hi", HI, 32'd1);
        check_output("nostall_lo", LO, 32'd2);

        // Reset during busy cycle 4 clears everything asynchronously.
        @(negedge clk);
        MDop = 4'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        MDop = 4'd0;
        for (int i = 1; i < 4; i++) @(negedge clk);
        check_output("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("rst_async_busy", {31'd0, busy}, 32'd0);
        check_output("rst_async_hi", HI, 32'd0);
        check_output("rst_async_lo", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check_output("rst_after_busy", {31'd0, busy}, 32'd0);
        check_output("rst_after_hi", HI, 32'd0);
        check_output("rst_after_lo", LO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the E stage of the P7 pipeline. It sits beside the E-stage ALU and owns the HI/LO registers.
- Sequences mult/multu/div/divu over a fixed latency and executes mthi/mtlo.
- Drives the D-stage stall when an MD-class instruction would collide with an operation in flight.
- Suppresses operation starts when the M stage raises an exception or interrupt request.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  32  operand rs (E-stage forwarded value).
- B  input  32  operand rt (E-stage forwarded value).
- MDop  input  4  E-stage MD operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others treated as none.
- req  input  1  exception/interrupt flush. When 1, the E-stage op must not take effect.
- D_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- start  output  1  combinational: MDop in 1..4 && !req && !busy.
- busy  output  1  registered: operation in flight.
- stall  output  1  combinational: D_is_md && (busy || start).
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - State goes to IDLE.
  - busy=0, HI=0, LO=0, counter=0, pending result cleared.
  - Reset asserted mid-operation abandons the operation; HI/LO do not receive its result.
- FSM states: IDLE, BUSY.
- IDLE, start=1:
  - At the edge, compute the result from A/B and latch it into hi_tmp/lo_tmp.
  - Load counter with MULT_CYCLES or DIV_CYCLES. Set busy=1. Go to BUSY.
- BUSY:
  - Counter decrements every edge.
  - On the edge where counter==1: HI<=hi_tmp, LO<=lo_tmp, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles after the start edge. The new HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: 64-bit signed product {HI,LO}=$signed(A)*$signed(B).
  - multu: 64-bit unsigned product.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. Special case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
- Divide by zero (B==0): the full DIV_CYCLES still elapse; HI/LO retain their pre-op values at completion.
- mthi/mtlo (MDop 5/6):
  - Write A into HI or LO at the next edge when !req && !busy. No busy cycles.
  - While busy these ops are ignored (the pipeline guarantees this through stall).
- MDop 1..4 while busy: ignored; busy, counter and tmp values are unchanged.
- req=1: start=0. mthi/mtlo are suppressed. An operation already in BUSY continues and commits normally.
- mfhi/mflo read HI/LO directly; the stall rule guarantees they never observe a pending result.

Test Plan:
- mult with A=0xFFFFFFFF, B=0x00000002:
  - busy stays high for 5 cycles.
  - Next cycle: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2:
  - After 10 busy cycles: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with A=7, B=2: LO=3, HI=1.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0.
  - busy high for 10 cycles.
  - HI=0x11, LO=0x22 afterward.
- Stall generation:
  - With D_is_md=1, stall=1 in the start cycle and in every busy cycle.
  - stall=0 the cycle busy falls.
  - D_is_md=0 while busy gives stall=0.
- req handling:
  - MDop=1 with req=1: start=0, busy stays 0, HI/LO unchanged.
  - mthi with req=1: HI unchanged.
  - req asserted during BUSY: the operation still commits.
- Reset mid-operation:
  - Start a div, drop reset_n at busy cycle 4.
  - busy, HI and LO go to 0 immediately without waiting for clk.
  - After release: stays IDLE, and no late commit occurs.
